// File: rtl/secuenciador_clasificador_pkg.sv
// Shared grade codes, FSM state encoding and the pure grading rule
// for the coffee-bean sorting sequencer.
package clasificador_pkg;

    localparam logic [1:0] GRADO_NINGUNO = 2'b00;
    localparam logic [1:0] GRADO_BAJA    = 2'b01;
    localparam logic [1:0] GRADO_MEDIA   = 2'b10;
    localparam logic [1:0] GRADO_ALTA    = 2'b11;

    typedef enum logic [2:0] {
        REPOSO,
        ESTABILIZAR,
        MUESTREAR,
        ACTUAR,
        LIBERAR
    } estado_e;

    // Number of sensors reporting OK decides the grade: 3 alta, 2 media, else baja.
    function automatic logic [1:0] clasificar(input logic tamano,
                                              input logic peso,
                                              input logic color);
        logic [1:0] n;
        n = 2'(tamano) + 2'(peso) + 2'(color);
        if (n == 2'd3)      return GRADO_ALTA;
        else if (n == 2'd2) return GRADO_MEDIA;
        else                return GRADO_BAJA;
    endfunction

endpackage

// File: rtl/secuenciador_clasificador_if.sv
// Feeder/sensor/actuator bundle of the sorter; the sequencer uses the
// slave side, the surrounding plant (or bench) the master side.
interface secuenciador_clasificador_if #(
    parameter int CNT_W = 16
);
    logic             grano_presente;
    logic             sensor_tamano;
    logic             sensor_peso;
    logic             sensor_color;
    logic             borrar_contadores;
    logic             alimentador_listo;
    logic [1:0]       compuerta;
    logic [1:0]       grado;
    logic [CNT_W-1:0] cuenta_baja;
    logic [CNT_W-1:0] cuenta_media;
    logic [CNT_W-1:0] cuenta_alta;
    logic [CNT_W-1:0] cuenta_abortos;
    logic             atasco;

    modport master (
        output grano_presente, sensor_tamano, sensor_peso, sensor_color, borrar_contadores,
        input  alimentador_listo, compuerta, grado,
        input  cuenta_baja, cuenta_media, cuenta_alta, cuenta_abortos, atasco
    );

    modport slave (
        input  grano_presente, sensor_tamano, sensor_peso, sensor_color, borrar_contadores,
        output alimentador_listo, compuerta, grado,
        output cuenta_baja, cuenta_media, cuenta_alta, cuenta_abortos, atasco
    );
endinterface

// File: rtl/secuenciador_clasificador_contador.sv
// Saturating tally: counts inc pulses up to all-ones; clear has priority.
module contador_saturado #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         borrar,
    input  logic         inc,
    output logic [W-1:0] cuenta
);
    logic [W-1:0] cuenta_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cuenta_q <= '0;
        else if (borrar)
            cuenta_q <= '0;
        else if (inc && (cuenta_q != {W{1'b1}}))
            cuenta_q <= cuenta_q + 1'b1;
    end

    assign cuenta = cuenta_q;
endmodule

// File: rtl/secuenciador_clasificador.sv
// One sorting cycle per bean: settle, sample/grade, pulse the diverter,
// wait for the bean to clear (or flag a jam). Tallies live in contador_saturado.
module secuenciador_clasificador
    import clasificador_pkg::*;
#(
    parameter int SETTLE_CYC  = 16,
    parameter int ACT_CYC     = 32,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16,
    parameter int TMR_W       = 11
) (
    input logic                   clk,
    input logic                   reset,
    secuenciador_clasificador_if.slave bus
);
    estado_e          estado_q;
    logic [TMR_W-1:0] timer_q;
    logic [1:0]       compuerta_q;
    logic [1:0]       grado_q;
    logic             atasco_q;
    logic             listo_q;
    logic [1:0]       grado_s;
    logic [3:0]       inc;
    logic [3:0][CNT_W-1:0] cuentas;

    assign grado_s = clasificar(bus.sensor_tamano, bus.sensor_peso, bus.sensor_color);

    // Tally index: 0 baja, 1 media, 2 alta, 3 abortos.
    always_comb begin
        inc    = '0;
        inc[0] = (estado_q == MUESTREAR) && (grado_s == GRADO_BAJA);
        inc[1] = (estado_q == MUESTREAR) && (grado_s == GRADO_MEDIA);
        inc[2] = (estado_q == MUESTREAR) && (grado_s == GRADO_ALTA);
        inc[3] = (estado_q == ESTABILIZAR) && !bus.grano_presente;
    end

    // listo_q tracks (REPOSO && !atasco) one edge ahead, so every branch
    // that lands in REPOSO also sets it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q    <= REPOSO;
            timer_q     <= '0;
            compuerta_q <= GRADO_NINGUNO;
            grado_q     <= GRADO_NINGUNO;
            atasco_q    <= 1'b0;
            listo_q     <= 1'b1;
        end else begin
            case (estado_q)
                REPOSO: begin
                    if (bus.grano_presente && !atasco_q) begin
                        estado_q <= ESTABILIZAR;
                        timer_q  <= '0;
                        listo_q  <= 1'b0;
                    end else begin
                        listo_q  <= !atasco_q || bus.borrar_contadores;
                    end
                end
                ESTABILIZAR: begin
                    timer_q <= timer_q + 1'b1;
                    if (!bus.grano_presente) begin
                        estado_q <= REPOSO;
                        listo_q  <= 1'b1;
                    end else if (timer_q == TMR_W'(SETTLE_CYC - 1)) begin
                        estado_q <= MUESTREAR;
                    end
                end
                MUESTREAR: begin
                    grado_q     <= grado_s;
                    compuerta_q <= grado_s;
                    estado_q    <= ACTUAR;
                    timer_q     <= '0;
                end
                ACTUAR: begin
                    timer_q <= timer_q + 1'b1;
                    if (timer_q == TMR_W'(ACT_CYC - 1)) begin
                        compuerta_q <= GRADO_NINGUNO;
                        estado_q    <= LIBERAR;
                        timer_q     <= '0;
                    end
                end
                LIBERAR: begin
                    timer_q <= timer_q + 1'b1;
                    if (!bus.grano_presente) begin
                        estado_q <= REPOSO;
                        listo_q  <= 1'b1;
                    end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                        estado_q <= REPOSO;
                        atasco_q <= 1'b1;
                        listo_q  <= bus.borrar_contadores;
                    end
                end
                default: begin
                    estado_q    <= REPOSO;
                    compuerta_q <= GRADO_NINGUNO;
                    listo_q     <= !atasco_q;
                end
            endcase
            // Clear beats a simultaneous jam detection.
            if (bus.borrar_contadores)
                atasco_q <= 1'b0;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        contador_saturado #(.W(CNT_W)) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .borrar (bus.borrar_contadores),
            .inc    (inc[g]),
            .cuenta (cuentas[g])
        );
    end

    assign bus.alimentador_listo = listo_q;
    assign bus.compuerta         = compuerta_q;
    assign bus.grado             = grado_q;
    assign bus.atasco            = atasco_q;
    assign bus.cuenta_baja       = cuentas[0];
    assign bus.cuenta_media      = cuentas[1];
    assign bus.cuenta_alta       = cuentas[2];
    assign bus.cuenta_abortos    = cuentas[3];
endmodule
